// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sevenseg_pkg;

    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] code_t;

    // Code the downstream decoder renders as an unlit digit.
    localparam code_t BLANK_CODE = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/sevenseg_slot_timer.sv
// Cycle and slot counter for the display scan: cnt walks 0..REFRESH_DIV-1
// inside a slot, slot walks 0..NUM_DIGITS-1 inside a frame.
module sevenseg_slot_timer #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = $clog2(REFRESH_DIV),
    parameter int SLOT_W       = $clog2(NUM_DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              run,
    output logic [CNT_W-1:0]  cnt,
    output logic [SLOT_W-1:0] slot,
    output logic              guard_done,
    output logic              slot_end,
    output logic              frame_end
);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_DIV - 32'sd1);
    localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(BLANK_CYCLES - 32'sd1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_DIGITS - 32'sd1);

    logic [CNT_W-1:0]  cnt_r;
    logic [SLOT_W-1:0] slot_r;
    logic              slot_end_s;
    logic              frame_end_s;

    assign slot_end_s  = (cnt_r == CNT_LAST);
    assign frame_end_s = slot_end_s && (slot_r == SLOT_LAST);

    // Counters wrap exactly at their terminal values; clear parks both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            slot_r <= '0;
        end else if (clear) begin
            cnt_r  <= '0;
            slot_r <= '0;
        end else if (run) begin
            if (slot_end_s) begin
                cnt_r  <= '0;
                slot_r <= frame_end_s ? '0 : slot_r + SLOT_W'(1'b1);
            end else begin
                cnt_r  <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    assign cnt        = cnt_r;
    assign slot       = slot_r;
    assign guard_done = (cnt_r == GUARD_LAST);
    assign slot_end   = slot_end_s;
    assign frame_end  = frame_end_s;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display
// with a double-buffered digit bank and a blanking guard at the start of each slot.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [CODE_W*NUM_DIGITS-1:0] wr_codes,
    input  logic [NUM_DIGITS-1:0]        wr_dp,
    output logic [CODE_W-1:0]            digit_code,
    output logic                         dp_out,
    output logic [NUM_DIGITS-1:0]        anode_n,
    output logic                         frame_tick
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int SLOT_W = $clog2(NUM_DIGITS);
    localparam int BANK_W = CODE_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(BLANK_CYCLES - 32'sd1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [BANK_W-1:0]     BANK_BLANK = {NUM_DIGITS{BLANK_CODE}};

    if ((NUM_DIGITS < 32'sd2) || (NUM_DIGITS > 32'sd8)) begin : g_bad_num_digits
        $error("sevenseg_scan_ctrl: NUM_DIGITS must be in 2..8");
    end
    if (REFRESH_DIV < 32'sd4) begin : g_bad_refresh_div
        $error("sevenseg_scan_ctrl: REFRESH_DIV must be >= 4");
    end
    if ((BLANK_CYCLES < 32'sd1) || (BLANK_CYCLES > (REFRESH_DIV - 32'sd2))) begin : g_bad_blank
        $error("sevenseg_scan_ctrl: BLANK_CYCLES must be in 1..REFRESH_DIV-2");
    end

    scan_state_t state_r;
    scan_state_t state_nxt_s;

    logic [CNT_W-1:0]      cnt_s;
    logic [SLOT_W-1:0]     slot_s;
    logic                  guard_done_s;
    logic                  slot_end_s;
    logic                  frame_end_s;
    logic                  timer_clear_s;
    logic                  timer_run_s;

    logic [BANK_W-1:0]     active_codes_r;
    logic [NUM_DIGITS-1:0] active_dp_r;
    logic [BANK_W-1:0]     pend_codes_r;
    logic [NUM_DIGITS-1:0] pend_dp_r;
    logic                  pend_valid_r;

    logic                  boundary_s;
    logic                  swap_s;
    logic                  accept_s;
    logic                  pend_valid_nxt_s;
    logic [BANK_W-1:0]     bank_codes_nxt_s;
    logic [NUM_DIGITS-1:0] bank_dp_nxt_s;
    logic [SLOT_W-1:0]     slot_show_s;
    logic [CODE_W-1:0]     code_nxt_s;
    logic                  dp_nxt_s;
    logic [NUM_DIGITS-1:0] anode_nxt_s;

    sevenseg_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (timer_clear_s),
        .run        (timer_run_s),
        .cnt        (cnt_s),
        .slot       (slot_s),
        .guard_done (guard_done_s),
        .slot_end   (slot_end_s),
        .frame_end  (frame_end_s)
    );

    assign timer_clear_s = (state_r == IDLE) || !enable;
    assign timer_run_s   = !timer_clear_s;

    // FSM next-state; a counter past the guard window never holds the digit dark.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_nxt_s = GUARD;
                else        state_nxt_s = IDLE;
            end
            GUARD: begin
                if (!enable)                                     state_nxt_s = IDLE;
                else if (guard_done_s || (cnt_s > GUARD_LAST))   state_nxt_s = ON;
                else                                             state_nxt_s = GUARD;
            end
            ON: begin
                if (!enable)        state_nxt_s = IDLE;
                else if (slot_end_s) state_nxt_s = GUARD;
                else                 state_nxt_s = ON;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Bank swap, handshake and the output values for the state being entered.
    always_comb begin
        boundary_s = (state_r == IDLE) || ((state_r == ON) && frame_end_s);
        swap_s     = boundary_s && pend_valid_r;
        accept_s   = wr_valid && wr_ready;

        if (accept_s)    pend_valid_nxt_s = 1'b1;
        else if (swap_s) pend_valid_nxt_s = 1'b0;
        else             pend_valid_nxt_s = pend_valid_r;

        if (swap_s) begin
            bank_codes_nxt_s = pend_codes_r;
            bank_dp_nxt_s    = pend_dp_r;
        end else begin
            bank_codes_nxt_s = active_codes_r;
            bank_dp_nxt_s    = active_dp_r;
        end

        case (state_r)
            IDLE:  slot_show_s = '0;
            GUARD: slot_show_s = slot_s;
            ON: begin
                if (slot_end_s && frame_end_s) slot_show_s = '0;
                else if (slot_end_s)           slot_show_s = slot_s + SLOT_W'(1'b1);
                else                           slot_show_s = slot_s;
            end
            default: slot_show_s = '0;
        endcase

        if (state_nxt_s == IDLE) begin
            code_nxt_s = BLANK_CODE;
            dp_nxt_s   = 1'b0;
        end else begin
            code_nxt_s = bank_codes_nxt_s[CODE_W*slot_show_s +: CODE_W];
            dp_nxt_s   = bank_dp_nxt_s[slot_show_s];
        end

        if (state_nxt_s == ON) anode_nxt_s = ~(DIGIT0 << slot_show_s);
        else                   anode_nxt_s = '1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Pending and active digit banks; reset discards any pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_codes_r <= BANK_BLANK;
            active_dp_r    <= '0;
            pend_codes_r   <= BANK_BLANK;
            pend_dp_r      <= '0;
            pend_valid_r   <= 1'b0;
        end else begin
            active_codes_r <= bank_codes_nxt_s;
            active_dp_r    <= bank_dp_nxt_s;
            pend_valid_r   <= pend_valid_nxt_s;
            if (accept_s) begin
                pend_codes_r <= wr_codes;
                pend_dp_r    <= wr_dp;
            end
        end
    end

    // Registered display and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n    <= '1;
            digit_code <= BLANK_CODE;
            dp_out     <= 1'b0;
            wr_ready   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            anode_n    <= anode_nxt_s;
            digit_code <= code_nxt_s;
            dp_out     <= dp_nxt_s;
            wr_ready   <= !pend_valid_nxt_s;
            frame_tick <= swap_s;
        end
    end

endmodule
